// File: rtl/anim_pkg.sv
// Shared definitions for the animation datapath.
// Provides field widths and the frame/animation index types used by the
// limit decoder, the frame sequencer and the 7-segment pattern ROM.
package anim_pkg;
  localparam int FRAME_W = 5;
  localparam int ANIM_W  = 3;
  localparam int SPEED_W = 2;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [ANIM_W-1:0]  anim_t;
endpackage

// File: rtl/frame_sequencer_tick_prescaler.sv
// tick_prescaler: programmable-rate step generator for the frame sequencer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   enable      - 1 = count, 0 = hold count, no step
//   clear       - forces the count back to 0 and suppresses the step
//   speed       - step period = TICK_DIV >> speed
//   step        - high during the cycle in which the count sits at period-1
module tick_prescaler
  import anim_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int DIV_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] count;

  assign period = DIV_W'(TICK_DIV) >> speed;

  // ">=" rather than "==" so that a speed increase that leaves the count
  // above the new terminal value still produces a step on the next cycle
  // instead of running the counter all the way around.
  assign step = enable && !clear && (count >= period - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else if (enable) begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: steps a frame index 0..limit-1 at a programmable rate and
// restarts at frame 0 whenever the animation select changes.
// Optional feature macro: FRAME_SEQ_PINGPONG_EN (count up then back down
// instead of wrapping; wrap pulses on each arrival at frame 0).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   enable      - 1 = run, 0 = pause (frame and prescaler hold)
//   animation   - current animation select
//   limit       - frame count for the current animation (0 treated as 1)
//   speed       - step period = TICK_DIV >> speed
//   frame       - current frame index (registered)
//   frame_tick  - one-cycle pulse with each frame update
//   wrap        - one-cycle pulse when stepping returns the frame to 0
module frame_sequencer
  import anim_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int DIV_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  anim_t              animation,
  input  frame_t             limit,
  input  logic [SPEED_W-1:0] speed,
  output frame_t             frame,
  output logic               frame_tick,
  output logic               wrap
);

  anim_t  anim_q;
  frame_t eff_lim;
  frame_t last;
  logic   anim_change;
  logic   step;

  assign eff_lim     = (limit == '0) ? frame_t'(1) : limit;
  assign last        = eff_lim - frame_t'(1);
  assign anim_change = (animation != anim_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (anim_change),
    .speed  (speed),
    .step   (step)
  );

`ifdef FRAME_SEQ_PINGPONG_EN
  logic dir;  // 0 = counting up, 1 = counting down

  always_ff @(posedge clk) begin
    if (reset) begin
      anim_q     <= '0;
      frame      <= '0;
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
      dir        <= 1'b0;
    end else if (anim_change) begin
      anim_q     <= animation;
      frame      <= '0;
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
      dir        <= 1'b0;
    end else if (step) begin
      frame_tick <= 1'b1;
      if (!dir) begin
        // Already at or past the top while going up: only reachable after
        // the limit shrinks or with a single-frame limit. Restart at 0.
        if (frame >= last) begin
          frame <= '0;
          wrap  <= 1'b1;
          dir   <= 1'b0;
        end else begin
          frame <= frame + frame_t'(1);
          wrap  <= 1'b0;
          dir   <= ((frame + frame_t'(1)) == last);
        end
      end else begin
        if (frame <= frame_t'(1)) begin
          frame <= '0;
          wrap  <= 1'b1;
          dir   <= 1'b0;
        end else begin
          frame <= frame - frame_t'(1);
          wrap  <= 1'b0;
        end
      end
    end else begin
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      anim_q     <= '0;
      frame      <= '0;
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
    end else if (anim_change) begin
      anim_q     <= animation;
      frame      <= '0;
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
    end else if (step) begin
      frame_tick <= 1'b1;
      // ">=" also catches a frame left beyond a limit that just shrank.
      if (frame >= last) begin
        frame <= '0;
        wrap  <= 1'b1;
      end else begin
        frame <= frame + frame_t'(1);
        wrap  <= 1'b0;
      end
    end else begin
      frame_tick <= 1'b0;
      wrap       <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer with TICK_DIV=8. Expected frame updates
// (frame value, wrap flag, cycles since previous update or reset) are queued
// by the stimulus process; a monitor pops one entry per frame_tick.
module tb_frame_sequencer;
  import anim_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  anim_t              animation;
  frame_t             limit;
  logic [SPEED_W-1:0] speed;
  frame_t             frame;
  logic               frame_tick;
  logic               wrap;

  typedef struct {
    int f;
    int w;
    int gap;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  frame_sequencer #(
    .TICK_DIV (8),
    .DIV_W    (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .animation  (animation),
    .limit      (limit),
    .speed      (speed),
    .frame      (frame),
    .frame_tick (frame_tick),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: compares every frame update against the next queued entry.
  always @(negedge clk) begin
    if (reset) begin
      last_cyc = cyc;
    end else begin
      if (wrap && !frame_tick) begin
        checks++;
        errors++;
        $display("FAIL wrap_without_tick: wrap=1 frame_tick=0 at cycle %0d, required wrap only with tick", cyc);
      end
      if (frame_tick) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: frame=%0d wrap=%0d at cycle %0d, required no tick", frame, wrap, cyc);
        end else begin
          e = q.pop_front();
          checks += 3;
          if (int'(frame) != e.f) begin
            errors++;
            $display("FAIL tick_frame: got %0d, expected %0d (cycle %0d)", frame, e.f, cyc);
          end
          if (int'(wrap) != e.w) begin
            errors++;
            $display("FAIL tick_wrap: got %0d, expected %0d (frame %0d, cycle %0d)", wrap, e.w, e.f, cyc);
          end
          if ((cyc - last_cyc) != e.gap) begin
            errors++;
            $display("FAIL tick_gap: got %0d cycles, expected %0d (frame %0d, cycle %0d)", cyc - last_cyc, e.gap, e.f, cyc);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push(input int f, input int w, input int gap);
    exp_t x;
    x.f   = f;
    x.w   = w;
    x.gap = gap;
    q.push_back(x);
  endtask

  // Advance n rising edges, then settle just after the following falling edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d updates outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_idle(input string name, input int f);
    checks += 3;
    if (int'(frame) != f) begin
      errors++;
      $display("FAIL %s_frame: got %0d, expected %0d", name, frame, f);
    end
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s_tick: got %0b, expected 0", name, frame_tick);
    end
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL %s_wrap: got %0b, expected 0", name, wrap);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    animation = '0;
    limit     = 5'd10;
    speed     = 2'd0;
    cycles(3);
    check_idle("reset", 0);

    // Speed 0, limit 10: step every 8 cycles, wrap on the 10th step.
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 9; i++) push(i, 0, 8);
    push(0, 1, 8);
    drain("count10");

    // Speed 3, limit 7: one step per cycle, wrap every 7 steps.
    speed = 2'd3;
    limit = 5'd7;
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 6; i++) push(i, 0, 1);
      push(0, 1, 1);
    end
    drain("fast7");

    // Back to speed 0, limit 10; run to frame 5.
    speed = 2'd0;
    limit = 5'd10;
    for (int i = 1; i <= 5; i++) push(i, 0, 8);
    drain("to5");

    // Animation change lands in the cycle that would have stepped.
    cycles(7);
    animation = 3'd1;
    push(1, 0, 16);
    cycles(1);
    check_idle("anim_change", 0);
    drain("after_anim");

    // Limit 0 behaves as 1: every step wraps to 0.
    limit = 5'd0;
    for (int i = 0; i < 3; i++) push(0, 1, 8);
    drain("limit0");

    // Pause mid-count for 20 cycles: no pulses, prescaler holds its count.
    cycles(3);
    enable = 1'b0;
    cycles(20);
    check_idle("pause", 0);
    enable = 1'b1;
    push(0, 1, 28);
    drain("resume");

    // Limit shrinks while frame sits at 9.
    limit = 5'd10;
    for (int i = 1; i <= 9; i++) push(i, 0, 8);
    drain("to9");
    limit = 5'd7;
    push(0, 1, 8);
    drain("shrink");

    // Reset mid-count; anim_q returns to 0 so the held select (1) then
    // registers as a change, costing one extra cycle before counting.
    push(1, 0, 8);
    push(2, 0, 8);
    drain("pre_reset");
    cycles(3);
    reset = 1'b1;
    cycles(1);
    check_idle("mid_reset", 0);
    reset = 1'b0;
    push(1, 0, 9);
    drain("post_reset");

    // Limit 4 at full speed, starting from frame 1.
    speed = 2'd3;
    limit = 5'd4;
`ifdef FRAME_SEQ_PINGPONG_EN
    push(2, 0, 1); push(3, 0, 1); push(2, 0, 1); push(1, 0, 1);
    push(0, 1, 1); push(1, 0, 1); push(2, 0, 1);
`else
    push(2, 0, 1); push(3, 0, 1); push(0, 1, 1); push(1, 0, 1);
    push(2, 0, 1); push(3, 0, 1); push(0, 1, 1);
`endif
    drain("limit4");
    enable = 1'b0;
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Downstream consumer of the per-animation frame-limit decoder.
- Steps a frame index 0..limit-1 at a programmable rate and wraps at the limit.
- Restarts cleanly whenever the animation select changes.
- Feeds the 7-segment pattern ROM, which maps (animation, frame) to segments.

Parameters:
- TICK_DIV, 5_000_000, clock cycles per frame step at speed 0; must be ≥ 8.
- DIV_W, 24, prescaler counter width; must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = run, 0 = pause (frame and prescaler hold)
- animation  input  3  current animation select, same bus that drives the limit decoder
- limit  input  5  frame count for the current animation, from the limit decoder; 0 treated as 1
- speed  input  2  step period = TICK_DIV >> speed (speed 3 = 8x faster)
- frame  output  5  current frame index, registered
- frame_tick  output  1  one-cycle pulse, coincident with each frame update
- wrap  output  1  one-cycle pulse when the sequence returns to frame 0 through stepping

Behaviour:
- Reset values: frame=0, frame_tick=0, wrap=0, prescaler=0, anim_q=0. Reset overrides all other inputs in the same cycle.
- Effective limit: eff_lim = (limit==0) ? 1 : limit.
- Period: period = TICK_DIV >> speed, computed combinationally at DIV_W bits.
- Prescaler, when enable=1:
  - counts 0..period-1;
  - at period-1 it returns to 0 and asserts an internal step for one cycle.
- Prescaler, when enable=0: holds its value; no step is generated.
- Step handling (registered; frame, frame_tick and wrap update on the clock edge after the step condition):
  - If frame >= eff_lim-1: frame←0, wrap←1.
  - Otherwise: frame←frame+1, wrap←0.
  - frame_tick←1 on every step.
- Pulses: frame_tick and wrap are 0 in every cycle without a step.
- Animation change (animation != anim_q):
  - frame←0, prescaler←0, anim_q←animation;
  - frame_tick=0 and wrap=0 that cycle;
  - takes priority over a coincident step.
- Limit change without an animation change:
  - no immediate action;
  - the next step wraps to 0 if frame >= eff_lim-1 (covers frame beyond a shrunken limit).
- Speed change mid-count:
  - if prescaler >= new period-1, the next cycle produces a step and the prescaler goes to 0;
  - no lock-up.
- Limit 31 (default/unknown animation): frame counts 0..30, then wraps.
- Minimum step period is 1 cycle per frame for any legal TICK_DIV.

Optional Feature:
- FRAME_SEQ_PINGPONG_EN defined:
  - adds a registered direction bit, reset 0 = up;
  - counting up, reaching eff_lim-1 flips direction and the next step decrements;
  - counting down, reaching 0 flips to up, and wrap pulses on the step that lands on 0;
  - with eff_lim=1, frame stays 0 and wrap pulses every step;
  - an animation change resets direction to up;
  - when frame >= eff_lim-1 while counting up (for example after the limit shrinks), the step goes to 0 with a wrap pulse and direction set to up.
- Undefined: plain wrap-around as described above; no direction register is present.

Decomposition:
- Shared package anim_pkg:
  - FRAME_W=5, ANIM_W=3, SPEED_W=2;
  - typedef frame_t (logic [FRAME_W-1:0]);
  - typedef anim_t (logic [ANIM_W-1:0]).
- One sub-module, tick_prescaler:
  - parameters TICK_DIV and DIV_W;
  - inputs clk, reset, enable, clear, speed;
  - output step.
- frame_sequencer holds anim_q, frame, direction and the pulse registers.

Test Plan (TICK_DIV=8):
- Reset, then enable=1, speed=0, animation=0, limit=10 → frame steps every 8 cycles 0..9; on the 10th step frame=0 with wrap=1 for 1 cycle.
- speed=3, limit=7 → one step per cycle; frame_tick continuously high; frame 0..6 repeating; wrap pulses every 7 cycles.
- Running at frame=5, animation changes 0→1 in the same cycle a step would occur → frame=0, no frame_tick; next step occurs 8 cycles later.
- limit=0 → frame stays 0; wrap and frame_tick pulse on every step. Then enable=0 for 20 cycles → no pulses; prescaler and frame hold.
- frame=9 with limit=10, then limit changes to 7 → next step gives frame=0 with wrap=1. Also: reset asserted mid-count → all outputs 0 the following cycle.
- FRAME_SEQ_PINGPONG_EN, limit=4 → frame sequence 0,1,2,3,2,1,0,1…; wrap pulses on each arrival at 0.
